// File: rtl/icache_direct_pkg.sv
// cpu_types_pkg: shared word, cache frame and cache state types.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [29:0] tag_t;
    typedef struct packed {
        logic  valid;
        tag_t  tag;
        word_t data;
    } icache_frame_t;
    typedef enum logic {COMPARE, FETCH} icache_state_t;
    localparam int ICACHE_SETS = 16;
endpackage

// File: rtl/icache_direct_if.sv
// icache_direct_if: fetch-side and memory-side signals of the instruction cache.
interface icache_direct_if;
    import cpu_types_pkg::*;
    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;
    logic  flush;
    word_t hit_count;
    word_t miss_count;
    modport slave (
        input  imemREN, imemaddr, iwait, iload, flush,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );
    modport master (
        output imemREN, imemaddr, iwait, iload, flush,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_direct_array.sv
// icache_array: valid/tag/data storage with one read port, one write port and flash-clear.
module icache_array
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [IDX_W-1:0] rindex,
    output icache_frame_t    rframe,
    input  logic [IDX_W-1:0] windex,
    input  icache_frame_t    wframe,
    input  logic             wen,
    input  logic             flush_all
);
    logic [SETS-1:0] valid;
    tag_t            tags [SETS];
    word_t           data [SETS];
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST)
            valid <= '0;
        else if (flush_all)
            valid <= '0;
        else if (wen)
            valid[windex] <= wframe.valid;
    always_ff @(posedge CLK)
        if (wen && !flush_all) begin
            tags[windex] <= wframe.tag;
            data[windex] <= wframe.data;
        end
    assign rframe = {valid[rindex], tags[rindex], data[rindex]};
endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped one-word-per-line instruction cache with hit/miss counters.
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input logic             CLK,
    input logic             nRST,
    icache_direct_if.slave  bus
);
    localparam int IDX_W = $clog2(SETS);
    icache_state_t    state;
    word_t            miss_addr;
    icache_frame_t    frame;
    logic [IDX_W-1:0] index;
    tag_t             tag;
    logic             hit, miss, fill;
    assign index = bus.imemaddr[IDX_W+1:2];
    assign tag   = tag_t'(bus.imemaddr[31:IDX_W+2]);
    assign hit   = state == COMPARE && bus.imemREN && frame.valid && frame.tag == tag;
    assign miss  = state == COMPARE && bus.imemREN && !hit && !bus.flush;
    // A flush drops the in-flight fill even if memory answers in the same cycle.
    assign fill  = state == FETCH && !bus.iwait && !bus.flush;
    assign bus.ihit     = hit && !bus.flush;
    assign bus.imemload = bus.ihit ? frame.data : '0;
    assign bus.iREN     = state == FETCH;
    assign bus.iaddr    = miss_addr;
    icache_array #(.SETS(SETS)) u_array (
        .CLK       (CLK),
        .nRST      (nRST),
        .rindex    (index),
        .rframe    (frame),
        .windex    (miss_addr[IDX_W+1:2]),
        .wframe    ({1'b1, tag_t'(miss_addr[31:IDX_W+2]), bus.iload}),
        .wen       (fill),
        .flush_all (bus.flush)
    );
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            state          <= COMPARE;
            miss_addr      <= '0;
            bus.hit_count  <= '0;
            bus.miss_count <= '0;
        end else begin
            state <= (bus.flush || fill) ? COMPARE : miss ? FETCH : state;
            if (miss)
                miss_addr <= {bus.imemaddr[31:2], 2'b00};
            if (bus.ihit && bus.hit_count != '1)
                bus.hit_count <= bus.hit_count + 1'b1;
            if (miss && bus.miss_count != '1)
                bus.miss_count <= bus.miss_count + 1'b1;
        end
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed stimulus checked every cycle against a line-level cache model.
module tb_icache_direct;
    import cpu_types_pkg::*;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;
    icache_direct_if bus();
    icache_direct #(.SETS(16)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
    int tests = 0;
    int fails = 0;
    // Model: each of 16 lines remembers the full word address it holds.
    bit          m_valid [16];
    logic [29:0] m_word  [16];
    logic [31:0] m_data  [16];
    bit          m_fetching;
    logic [31:0] m_faddr, m_hits, m_misses, snap_h, snap_m;
    int          li;
    bit          e_hit;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    always @(negedge CLK) begin
        if (!nRST) begin
            chk("rst_ihit", bus.ihit, 0);
            chk("rst_iREN", bus.iREN, 0);
            chk("rst_iaddr", bus.iaddr, 0);
            chk("rst_imemload", bus.imemload, 0);
            chk("rst_hits", bus.hit_count, 0);
            chk("rst_misses", bus.miss_count, 0);
            for (int k = 0; k < 16; k++) m_valid[k] = 0;
            m_fetching = 0;
            m_faddr = 0;
            m_hits = 0;
            m_misses = 0;
        end else begin
            li = int'((bus.imemaddr >> 2) % 16);
            e_hit = !m_fetching && bus.imemREN && !bus.flush && m_valid[li] && m_word[li] == bus.imemaddr[31:2];
            chk("m_ihit", bus.ihit, e_hit);
            chk("m_imemload", bus.imemload, e_hit ? m_data[li] : 32'h0);
            chk("m_iREN", bus.iREN, m_fetching);
            if (m_fetching) chk("m_iaddr", bus.iaddr, m_faddr);
            chk("m_hits", bus.hit_count, m_hits);
            chk("m_misses", bus.miss_count, m_misses);
            if (e_hit) m_hits++;
            if (bus.flush) begin
                for (int k = 0; k < 16; k++) m_valid[k] = 0;
                m_fetching = 0;
            end else if (m_fetching) begin
                if (!bus.iwait) begin
                    m_valid[(m_faddr >> 2) % 16] = 1;
                    m_word[(m_faddr >> 2) % 16] = m_faddr[31:2];
                    m_data[(m_faddr >> 2) % 16] = bus.iload;
                    m_fetching = 0;
                end
            end else if (bus.imemREN && !e_hit) begin
                m_fetching = 1;
                m_faddr = {bus.imemaddr[31:2], 2'b00};
                m_misses++;
            end
        end
    end
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic settle();
        #2;
    endtask
    initial begin
        bus.imemREN = 0; bus.imemaddr = 0; bus.iwait = 1; bus.iload = 0; bus.flush = 0;
        repeat (2) tick();
        nRST = 1;
        settle();
        chk("init_hits", bus.hit_count, 0);
        chk("init_iREN", bus.iREN, 0);
        // cold miss with two wait cycles
        tick();
        bus.imemREN = 1; bus.imemaddr = 32'h40; bus.iload = 32'h2001_0005; bus.iwait = 1;
        settle();
        chk("cold_c0_ihit", bus.ihit, 0);
        chk("cold_c0_iREN", bus.iREN, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 2) bus.iwait = 0;
            settle();
            chk("cold_iREN", bus.iREN, 1);
            chk("cold_iaddr", bus.iaddr, 32'h40);
            chk("cold_ihit", bus.ihit, 0);
        end
        tick();
        bus.iwait = 1;
        settle();
        chk("cold_hit", bus.ihit, 1);
        chk("cold_load", bus.imemload, 32'h2001_0005);
        chk("cold_misses", bus.miss_count, 1);
        tick();
        bus.imemREN = 0;
        settle();
        chk("cold_hits", bus.hit_count, 1);
        chk("idle_ihit", bus.ihit, 0);
        // conflict on index 0
        tick();
        bus.imemREN = 1; bus.imemaddr = 32'h0; bus.iload = 32'hAAAA_0000; bus.iwait = 0;
        settle();
        chk("conf_miss", bus.ihit, 0);
        tick(); settle();
        chk("conf_iaddr", bus.iaddr, 32'h0);
        chk("conf_iREN", bus.iREN, 1);
        tick(); settle();
        chk("conf_hit", bus.ihit, 1);
        chk("conf_load", bus.imemload, 32'hAAAA_0000);
        tick();
        bus.imemaddr = 32'h40; bus.iload = 32'h2001_0005;
        settle();
        chk("conf_replaced", bus.ihit, 0);
        tick(); settle();
        chk("conf_iaddr40", bus.iaddr, 32'h40);
        tick(); settle();
        chk("conf_rehit", bus.ihit, 1);
        chk("conf_misses", bus.miss_count, 3);
        // redirect while the fill is outstanding
        tick();
        bus.imemaddr = 32'h104; bus.iload = 32'h1111_0104; bus.iwait = 1;
        settle();
        chk("redir_miss", bus.ihit, 0);
        tick();
        bus.imemaddr = 32'h200;
        settle();
        chk("redir_iaddr1", bus.iaddr, 32'h104);
        chk("redir_iREN", bus.iREN, 1);
        tick();
        bus.iwait = 0;
        settle();
        chk("redir_iaddr2", bus.iaddr, 32'h104);
        tick();
        bus.iload = 32'h2222_0200; bus.iwait = 1;
        settle();
        chk("redir_new_miss", bus.ihit, 0);
        tick(); settle();
        chk("redir_iaddr200", bus.iaddr, 32'h200);
        chk("redir_iREN2", bus.iREN, 1);
        bus.iwait = 0;
        tick(); settle();
        chk("redir_hit200", bus.ihit, 1);
        chk("redir_load200", bus.imemload, 32'h2222_0200);
        tick();
        bus.imemaddr = 32'h104;
        settle();
        chk("redir_hit104", bus.ihit, 1);
        chk("redir_load104", bus.imemload, 32'h1111_0104);
        // flush in the cycle memory answers
        tick();
        bus.imemaddr = 32'h80; bus.iwait = 1; bus.iload = 32'h3333_0080;
        settle();
        chk("fl_miss", bus.ihit, 0);
        tick(); settle();
        chk("fl_iaddr", bus.iaddr, 32'h80);
        tick();
        bus.iwait = 0; bus.flush = 1;
        settle();
        chk("fl_iREN_during", bus.iREN, 1);
        tick();
        bus.flush = 0; bus.iwait = 1;
        settle();
        chk("fl_iREN_after", bus.iREN, 0);
        chk("fl_not_installed", bus.ihit, 0);
        tick(); settle();
        chk("fl_refetch_iREN", bus.iREN, 1);
        bus.iwait = 0;
        tick(); settle();
        chk("fl_refetch_hit", bus.ihit, 1);
        chk("fl_refetch_load", bus.imemload, 32'h3333_0080);
        tick();
        bus.imemaddr = 32'h104; bus.iload = 32'h1111_0104; bus.iwait = 0;
        settle();
        chk("fl_cleared_104", bus.ihit, 0);
        tick(); tick(); settle();
        chk("fl_hit_104", bus.ihit, 1);
        // unaligned address and idle counters
        tick();
        bus.imemaddr = 32'h40; bus.iload = 32'h2001_0005;
        settle();
        chk("ua_miss40", bus.ihit, 0);
        tick(); tick(); settle();
        chk("ua_hit40", bus.ihit, 1);
        tick();
        bus.imemaddr = 32'h43;
        settle();
        chk("ua_hit43", bus.ihit, 1);
        chk("ua_load43", bus.imemload, 32'h2001_0005);
        tick();
        bus.imemREN = 0;
        settle();
        snap_h = m_hits;
        snap_m = m_misses;
        repeat (3) begin
            tick(); settle();
            chk("idle_ihit2", bus.ihit, 0);
            chk("idle_hits", bus.hit_count, snap_h);
            chk("idle_misses", bus.miss_count, snap_m);
        end
        // asynchronous reset during a fill
        tick();
        bus.imemREN = 1; bus.imemaddr = 32'h300; bus.iwait = 1;
        settle();
        tick(); settle();
        chk("ar_iREN_before", bus.iREN, 1);
        tick();
        #1 nRST = 0;
        #1;
        chk("ar_iREN_now", bus.iREN, 0);
        chk("ar_hits", bus.hit_count, 0);
        chk("ar_misses", bus.miss_count, 0);
        tick();
        nRST = 1; bus.imemaddr = 32'h40; bus.iwait = 0;
        settle();
        chk("ar_miss40", bus.ihit, 0);
        tick(); settle();
        chk("ar_fetch", bus.iREN, 1);
        chk("ar_misses1", bus.miss_count, 1);
        tick(); settle();
        chk("ar_hit40", bus.ihit, 1);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
